// File: rtl/flash_byte_streamer.sv
// Streams a packed flash read buffer out one byte at a time over a valid/ready handshake.
// Optional macro FLASH_ERASED_SKIP_EN: erased bytes (0xFF) are consumed without being offered.
module flash_byte_streamer #(
    parameter int MEMORY_LENGTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MEMORY_LENGTH*8-1:0] dataBuffer,
    input  logic                       loadStrobe,
    output logic [7:0]                 byteOut,
    output logic                       byteValid,
    input  logic                       byteReady,
    output logic [7:0]                 byteIndex,
    output logic                       busy,
    output logic                       done
);

    localparam int         BUF_W    = MEMORY_LENGTH * 8;
    localparam logic [7:0] LAST_IDX = 8'(MEMORY_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [BUF_W-1:0]   shift_r;
    logic [7:0]         index_r;
    logic [7:0]         top_byte_s;
    logic               skip_s;
    logic               valid_s;
    logic               consume_s;

    assign top_byte_s = shift_r[BUF_W-1 -: 8];

`ifdef FLASH_ERASED_SKIP_EN
    // An erased byte at the head of the register is dropped without a handshake.
    assign skip_s = (state_r == SEND) && (top_byte_s == 8'hFF);
`else
    assign skip_s = 1'b0;
`endif

    // Offer/consume decision for the byte at the head of the shift register.
    always_comb begin
        valid_s   = 1'b0;
        consume_s = 1'b0;
        case (state_r)
            SEND: begin
                if (skip_s) begin
                    valid_s   = 1'b0;
                    consume_s = 1'b1;
                end else begin
                    valid_s   = 1'b1;
                    consume_s = byteReady;
                end
            end
            default: begin
                valid_s   = 1'b0;
                consume_s = 1'b0;
            end
        endcase
    end

    // Outputs come straight from state and data registers so there is no added latency.
    assign byteValid = valid_s;
    assign byteOut   = top_byte_s;
    assign byteIndex = index_r;
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);

    // Sequencer: capture on load, shift out on each consumed byte, pulse DONE once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= '0;
            index_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (loadStrobe) begin
                        shift_r <= dataBuffer;
                        index_r <= 8'd0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (consume_s) begin
                        // Zero-fill keeps byteOut at 0x00 once every byte has gone.
                        shift_r <= shift_r << 4'd8;
                        index_r <= index_r + 8'd1;
                        if (index_r == LAST_IDX) begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_byte_streamer.sv
// Self-checking bench for flash_byte_streamer: directed spec scenarios plus a randomized run
// against a queue-based model of the byte stream.
module tb_flash_byte_streamer;

    localparam int ML = 5;
`ifdef FLASH_ERASED_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [39:0] HELLO = 40'h68656C6C6F;
    localparam logic [39:0] WORLD = 40'h776F726C64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [ML*8-1:0] dataBuffer = '0;
    logic [7:0]    dataBuffer1 = 8'h00;
    logic          loadStrobe = 1'b0;
    logic          byteReady = 1'b0;
    logic [7:0]    byteOut, byteIndex, byteOut1, byteIndex1;
    logic          byteValid, busy, done, byteValid1, busy1, done1;

    int errors = 0;
    int checks = 0;

    flash_byte_streamer #(.MEMORY_LENGTH(ML)) u_dut (
        .clk(clk), .reset(reset), .dataBuffer(dataBuffer), .loadStrobe(loadStrobe),
        .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady),
        .byteIndex(byteIndex), .busy(busy), .done(done)
    );

    flash_byte_streamer #(.MEMORY_LENGTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .dataBuffer(dataBuffer1), .loadStrobe(loadStrobe),
        .byteOut(byteOut1), .byteValid(byteValid1), .byteReady(byteReady),
        .byteIndex(byteIndex1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    wire [18:0] obs  = {byteValid, byteIndex, byteOut, busy, done};
    wire [18:0] obs1 = {byteValid1, byteIndex1, byteOut1, busy1, done1};
    wire [2:0]  ctl  = {byteValid, busy, done};
    wire [2:0]  ctl1 = {byteValid1, busy1, done1};

    function automatic logic [18:0] ew(input logic v, input logic [7:0] i,
                                       input logic [7:0] o, input logic b, input logic d);
        return {v, i, o, b, d};
    endfunction

    function automatic logic [7:0] byte_of(input logic [39:0] b, input int k);
        return b[(ML-1-k)*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; loadStrobe = 1'b0; step(); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; loadStrobe = 1'b1; byteReady = 1'b1; dataBuffer = HELLO;
        step(); step();
        checks++;
        if (obs !== ew(1'b0, 8'h00, 8'h00, 1'b0, 1'b0))
            $display("FAIL reset_state got=%h exp=%h", obs, ew(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        if (obs !== ew(1'b0, 8'h00, 8'h00, 1'b0, 1'b0)) errors++;
        reset = 1'b0; loadStrobe = 1'b0;
    endtask

    task automatic test_len1();
        pulse_reset();
        dataBuffer1 = 8'h5A; loadStrobe = 1'b1; byteReady = 1'b1; step(); loadStrobe = 1'b0;
        checks++;
        if (obs1 !== ew(1'b1, 8'h00, 8'h5A, 1'b1, 1'b0)) begin
            errors++; $display("FAIL len1_byte got=%h exp=%h", obs1, ew(1'b1, 8'h00, 8'h5A, 1'b1, 1'b0));
        end
        step();
        checks++;
        if (ctl1 !== 3'b011) begin errors++; $display("FAIL len1_done got=%b exp=011", ctl1); end
        step();
        checks++;
        if (ctl1 !== 3'b000) begin errors++; $display("FAIL len1_idle got=%b exp=000", ctl1); end
    endtask

    task automatic test_hello();
        pulse_reset();
        dataBuffer = HELLO; loadStrobe = 1'b1; byteReady = 1'b1; step(); loadStrobe = 1'b0;
        for (int k = 0; k < ML; k++) begin
            checks++;
            if (obs !== ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0)) begin
                errors++; $display("FAIL hello k=%0d got=%h exp=%h", k, obs, ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0));
            end
            step();
        end
        checks++;
        if (ctl !== 3'b011) begin errors++; $display("FAIL hello_done got=%b exp=011", ctl); end
        step();
        checks++;
        if (ctl !== 3'b000) begin errors++; $display("FAIL hello_idle got=%b exp=000", ctl); end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        dataBuffer = HELLO; loadStrobe = 1'b1; byteReady = 1'b0; step(); loadStrobe = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            byteReady = (c == 4);
            checks++;
            if (obs !== ew(1'b1, 8'h00, 8'h68, 1'b1, 1'b0)) begin
                errors++; $display("FAIL hold c=%0d got=%h exp=%h", c, obs, ew(1'b1, 8'h00, 8'h68, 1'b1, 1'b0));
            end
            step();
        end
        for (int k = 1; k < ML; k++) begin
            checks++;
            if (obs !== ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0)) begin
                errors++; $display("FAIL bp_stream k=%0d got=%h exp=%h", k, obs, ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0));
            end
            step();
        end
        checks++;
        if (ctl !== 3'b011) begin errors++; $display("FAIL bp_done got=%b exp=011", ctl); end
    endtask

    task automatic test_ignored_load();
        pulse_reset();
        dataBuffer = HELLO; loadStrobe = 1'b1; byteReady = 1'b1; step(); loadStrobe = 1'b0;
        for (int k = 0; k < ML; k++) begin
            if (k == 1) begin dataBuffer = WORLD; loadStrobe = 1'b1; end
            else loadStrobe = 1'b0;
            checks++;
            if (obs !== ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0)) begin
                errors++; $display("FAIL ign_stream k=%0d got=%h exp=%h", k, obs, ew(1'b1, 8'(k), byte_of(HELLO, k), 1'b1, 1'b0));
            end
            step();
        end
        // load during the DONE cycle is dropped, the one right after it is taken
        loadStrobe = 1'b1;
        checks++;
        if (ctl !== 3'b011) begin errors++; $display("FAIL ign_done got=%b exp=011", ctl); end
        step();
        checks++;
        if (ctl !== 3'b000) begin errors++; $display("FAIL ign_idle got=%b exp=000", ctl); end
        step(); loadStrobe = 1'b0;
        checks++;
        if (obs !== ew(1'b1, 8'h00, 8'h77, 1'b1, 1'b0)) begin
            errors++; $display("FAIL reload got=%h exp=%h", obs, ew(1'b1, 8'h00, 8'h77, 1'b1, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        dataBuffer = HELLO; loadStrobe = 1'b1; byteReady = 1'b1; step(); loadStrobe = 1'b0;
        step(); step();
        checks++;
        if (obs !== ew(1'b1, 8'h02, 8'h6C, 1'b1, 1'b0)) begin
            errors++; $display("FAIL pre_reset got=%h exp=%h", obs, ew(1'b1, 8'h02, 8'h6C, 1'b1, 1'b0));
        end
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs !== ew(1'b0, 8'h00, 8'h00, 1'b0, 1'b0)) begin
                errors++; $display("FAIL mid_reset c=%0d got=%h exp=%h", c, obs, ew(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
            end
            step();
        end
        dataBuffer = WORLD; loadStrobe = 1'b1; step(); loadStrobe = 1'b0;
        checks++;
        if (obs !== ew(1'b1, 8'h00, 8'h77, 1'b1, 1'b0)) begin
            errors++; $display("FAIL post_reset_load got=%h exp=%h", obs, ew(1'b1, 8'h00, 8'h77, 1'b1, 1'b0));
        end
    endtask

    task automatic test_erased();
        logic [39:0] ffbuf;
        ffbuf = 40'h68FF65FFFF;
        pulse_reset();
        dataBuffer = ffbuf; loadStrobe = 1'b1; byteReady = 1'b1; step(); loadStrobe = 1'b0;
        for (int k = 0; k < ML; k++) begin
            logic ev;
            ev = !(SKIP && byte_of(ffbuf, k) == 8'hFF);
            checks++;
            if (obs !== ew(ev, 8'(k), byte_of(ffbuf, k), 1'b1, 1'b0)) begin
                errors++; $display("FAIL erased k=%0d got=%h exp=%h", k, obs, ew(ev, 8'(k), byte_of(ffbuf, k), 1'b1, 1'b0));
            end
            step();
        end
        checks++;
        if (ctl !== 3'b011) begin errors++; $display("FAIL erased_done got=%b exp=011", ctl); end
    endtask

    task automatic test_random();
        logic [7:0] mq[$];
        int         midx;
        bit         mdone;
        logic [7:0] nb[ML];
        logic [ML*8-1:0] pk;
        bit         ld, rdy, rst, sending, ev, eb, ed;
        pulse_reset();
        mq = {}; midx = 0; mdone = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            sending = (mq.size() > 0);
            ev = sending && !(SKIP && mq[0] == 8'hFF);
            eb = sending || mdone;
            ed = !sending && mdone;
            checks++;
            if (ctl !== {ev, eb, ed}) begin
                errors++; $display("FAIL rand_ctl c=%0d got=%b exp=%b", c, ctl, {ev, eb, ed});
            end
            if (sending) begin
                checks++;
                if ({byteOut, byteIndex} !== {mq[0], 8'(midx)}) begin
                    errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, {byteOut, byteIndex}, {mq[0], 8'(midx)});
                end
            end
            for (int k = 0; k < ML; k++) begin
                nb[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                pk[(ML-1-k)*8 +: 8] = nb[k];
            end
            ld  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 79) == 0);
            dataBuffer = pk; loadStrobe = ld; byteReady = rdy; reset = rst;
            step();
            if (rst) begin
                mq = {}; midx = 0; mdone = 1'b0;
            end else if (sending) begin
                if (!ev || rdy) begin
                    void'(mq.pop_front());
                    midx++;
                    if (mq.size() == 0) mdone = 1'b1;
                end
            end else if (mdone) begin
                mdone = 1'b0;
            end else if (ld) begin
                for (int k = 0; k < ML; k++) mq.push_back(nb[k]);
                midx = 0;
            end
        end
        reset = 1'b0; loadStrobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_len1();
        test_hello();
        test_backpressure();
        test_ignored_load();
        test_reset_mid();
        test_erased();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_byte_streamer.md
FLASH_BYTE_STREAMER -- requirements
Module: flash_byte_streamer

Interface
REQ-001 SHALL have parameter MEMORY_LENGTH, default 5, meaning the number of bytes in the packed input buffer (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port dataBuffer  input  MEMORY_LENGTH*8  packed flash read data; byte 0 occupies the most significant 8 bits.
REQ-005 SHALL have port loadStrobe  input  1  one-cycle pulse: dataBuffer is valid this cycle.
REQ-006 SHALL have port byteOut  output  8  current byte offered downstream.
REQ-007 SHALL have port byteValid  output  1  byteOut is valid.
REQ-008 SHALL have port byteReady  input  1  downstream accepts byteOut this cycle.
REQ-009 SHALL have port byteIndex  output  8  index (0-based) of the byte currently on byteOut.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last byte is consumed.

Function
REQ-012 SHALL implement the states IDLE, SEND and DONE.
REQ-013 IDLE: on loadStrobe=1, SHALL capture dataBuffer into an internal shift register, clear byteIndex to 0 and enter SEND on the next edge.
REQ-014 SHALL latch the buffer in the same cycle as loadStrobe; byteValid SHALL rise in the following cycle with byteOut = byte 0.
REQ-015 SEND: byteOut SHALL equal the top byte of the shift register, and byteValid SHALL be 1, except where REQ-030 applies.
REQ-016 A transfer occurs on any edge where byteValid=1 and byteReady=1; a transfer SHALL shift the register left by 8 bits and increment byteIndex.
REQ-017 While byteValid=1 and byteReady=0, byteOut and byteIndex SHALL be held stable.
REQ-018 byteReady SHALL be ignored whenever byteValid=0.
REQ-019 When a transfer or skip consumes byte MEMORY_LENGTH-1, the FSM SHALL move to DONE; there SHALL be no wrap to byte 0.
REQ-020 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-021 loadStrobe in SEND or DONE SHALL be ignored; the captured data SHALL not change.
REQ-022 loadStrobe in IDLE SHALL be accepted on the very cycle after the DONE pulse.
REQ-023 byteValid and done SHALL be driven directly from the state and data registers (combinational outputs); they SHALL not add a registered latency stage.
REQ-024 The index counter SHALL be 8 bits wide and SHALL compare against MEMORY_LENGTH-1.
REQ-025 MEMORY_LENGTH=1: a single transfer SHALL lead to DONE.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, byteValid=0, busy=0, done=0, byteIndex=0 and byteOut=0x00, and SHALL clear the shift register.
REQ-027 reset SHALL take priority over loadStrobe and byteReady on the same edge.
REQ-028 Reset mid-SEND SHALL abandon the remaining bytes with no done pulse.

Configuration
REQ-029 SHALL support the macro FLASH_ERASED_SKIP_EN.
REQ-030 With FLASH_ERASED_SKIP_EN defined: in SEND, if the top byte is 0xFF (erased flash), byteValid SHALL be 0 for that cycle and the byte SHALL be consumed on that edge (shift, index+1) with no handshake; one cycle SHALL elapse per skipped byte.
REQ-031 With FLASH_ERASED_SKIP_EN undefined: 0xFF SHALL be streamed like any other byte, and the skip logic SHALL be absent.

Verification
REQ-032 SHALL cover: MEMORY_LENGTH=5, dataBuffer="hello", loadStrobe at cycle N, byteReady held 1 -> byteOut 0x68,0x65,0x6C,0x6C,0x6F with byteValid in cycles N+1..N+5, byteIndex 0..4, done at N+6, busy low at N+7.
REQ-033 SHALL cover: same load with byteReady=0 for cycles N+1..N+3, then 1 -> byteOut 0x68 with byteIndex 0 stable through N+3; 0x65 appears at N+5; done at N+9.
REQ-034 SHALL cover: second loadStrobe carrying "world" at N+2 during the "hello" stream -> ignored; output remains exactly "hello".
REQ-035 SHALL cover: reset pulsed at N+3 during the "hello" stream -> next cycle byteValid=0, busy=0, byteIndex=0, byteOut=0x00; no done pulse; a new load is then accepted normally.
REQ-036 SHALL cover (FLASH_ERASED_SKIP_EN defined): dataBuffer=0x68FF65FFFF, byteReady=1 -> only 0x68 at N+1 (index 0) and 0x65 at N+3 (index 2) are transferred; done at N+6.
REQ-037 SHALL cover (FLASH_ERASED_SKIP_EN undefined): the same 0x68FF65FFFF input -> all five bytes are presented, including 0xFF at indices 1, 3 and 4.
